fxp_dot_accum: RTL and testbench

- Sequential Q16.16 multiply-accumulate stage that sits directly downstream of the combinational fixed-point add/multiply operator.
- Accepts a stream of VEC_LEN operand pairs over a valid/ready handshake and computes the dot product.
- Returns one saturated Q16.16 result per vector on an output valid/ready handshake.
- Multiply arithmetic is identical to the operator's multiply path: full signed product, arithmetic right shift by FRAC.

---
 rtl/fxp_dot_accum.sv | 118 +++++++++++
 tb/tb_fxp_dot_accum.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_dot_accum.sv
// Q16.16 multiply-accumulate: consumes VEC_LEN operand pairs over valid/ready and returns
// one saturated dot product per vector over an output valid/ready handshake.
module fxp_dot_accum #(
    parameter int unsigned W       = 32,
    parameter int unsigned FRAC    = 16,
    parameter int unsigned VEC_LEN = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_valid,
    input  logic signed [W-1:0] din_1,
    input  logic signed [W-1:0] din_2,
    output logic                o_ready,
    output logic signed [W-1:0] dout,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_sat
);

    localparam int unsigned ACC_W = 2 * W - FRAC + $clog2(VEC_LEN);
    localparam int unsigned CW    = $clog2(VEC_LEN + 1);
    localparam int unsigned UW    = ACC_W - W + 1;

    localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                state;
    logic [CW-1:0]             count;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   p_reg;
    logic                      p_vld;

    logic signed [2*W-1:0]     prod_full;
    logic signed [2*W-1:0]     prod_sh;
    logic signed [ACC_W-1:0]   prod_ext;
    logic [UW-1:0]             acc_upper;
    logic                      sat_flag;
    logic signed [W-1:0]       sat_val;

    // Full-width signed product, floored by the arithmetic shift; the shifted value always fits
    // in ACC_W bits so the resize only drops redundant sign bits.
    assign prod_full = (2 * W)'(din_1) * (2 * W)'(din_2);
    assign prod_sh   = prod_full >>> FRAC;
    assign prod_ext  = ACC_W'(prod_sh);

    assign o_ready = (state == ACCUM);

    // Result fits in W bits only when every bit from W-1 upward matches the sign.
    always_comb begin
        acc_upper = acc[ACC_W-1:W-1];
        sat_flag  = !((&acc_upper) || (~|acc_upper));
        sat_val   = acc[W-1:0];
        if (sat_flag) begin
            sat_val = acc[ACC_W-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            p_reg   <= '0;
            p_vld   <= 1'b0;
            dout    <= '0;
            o_valid <= 1'b0;
            o_sat   <= 1'b0;
        end else begin
            if (p_vld) begin
                acc <= acc + p_reg;
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        acc   <= '0;
                        count <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (i_valid) begin
                        p_reg <= prod_ext;
                        p_vld <= 1'b1;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state <= DRAIN;
                        end
                    end else begin
                        p_vld <= 1'b0;
                    end
                end
                DRAIN: begin
                    p_vld <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    // First DONE edge publishes the result; later edges wait for the consumer.
                    if (!o_valid) begin
                        dout    <= sat_val;
                        o_sat   <= sat_flag;
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        o_sat   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_dot_accum.sv
// Scoreboard bench for fxp_dot_accum: a VEC_LEN=4 instance for most vectors and a VEC_LEN=1
// instance for the single-pair cases; monitors pop expected results on each output handshake.
module tb_fxp_dot_accum;

    logic        clk = 1'b0;
    logic        rst, start, start1, valid, ready, ready1;
    logic [31:0] a, b;
    logic        o_ready, o_valid, o_sat;
    logic [31:0] dout;
    logic        o_ready1, o_valid1, o_sat1;
    logic [31:0] dout1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [32:0] q4[$];
    logic [32:0] q1[$];
    logic [32:0] e4, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fxp_dot_accum #(.W(32), .FRAC(16), .VEC_LEN(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_valid(valid),
        .din_1(a), .din_2(b), .o_ready(o_ready), .dout(dout),
        .o_valid(o_valid), .i_ready(ready), .o_sat(o_sat)
    );

    fxp_dot_accum #(.W(32), .FRAC(16), .VEC_LEN(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_valid(valid),
        .din_1(a), .din_2(b), .o_ready(o_ready1), .dout(dout1),
        .o_valid(o_valid1), .i_ready(ready1), .o_sat(o_sat1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && ready) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got 0x%08h, expected no result", dout);
            end else begin
                e4 = q4.pop_front();
                chk("dout", dout, e4[31:0]);
                chk("o_sat", {31'b0, o_sat}, {31'b0, e4[32]});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && o_valid1 && ready1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result1: got 0x%08h, expected no result", dout1);
            end else begin
                e1 = q1.pop_front();
                chk("dout1", dout1, e1[31:0]);
                chk("o_sat1", {31'b0, o_sat1}, {31'b0, e1[32]});
            end
        end
    end

    // One 4-pair vector of a repeated operand pair; vpat/plen give the leading i_valid pattern,
    // hold is the number of DONE cycles with i_ready low (0 = i_ready high throughout).
    task automatic run_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                           input logic [6:0] vpat, input int plen, input int hold,
                           input logic [31:0] exp_d, input logic exp_s);
        int acc_n;
        int i;
        int last;
        int n;
        q4.push_back({exp_s, exp_d});
        ready = (hold == 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({name, "_ready_accum"}, {31'b0, o_ready}, 32'd1);
        acc_n = 0;
        i = 0;
        while (acc_n < 4) begin
            valid = (i < plen) ? vpat[i] : 1'b1;
            a = valid ? va : 32'hDEAD_BEEF;
            b = valid ? vb : 32'h7654_3210;
            if (valid) acc_n++;
            i++;
            @(posedge clk); #1;
        end
        last = cyc;
        valid = 1'b0;
        a = 32'h1234_5678;
        b = 32'h8765_4321;
        n = 0;
        while (!o_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 32'(cyc - last), 32'd2);
        chk({name, "_ready_done"}, {31'b0, o_ready}, 32'd0);
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                valid = k[0];
                chk({name, "_hold_dout"}, dout, exp_d);
                chk({name, "_hold_sat"}, {31'b0, o_sat}, {31'b0, exp_s});
                chk({name, "_hold_valid"}, {31'b0, o_valid}, 32'd1);
                chk({name, "_hold_ready"}, {31'b0, o_ready}, 32'd0);
                @(posedge clk); #1;
            end
            valid = 1'b0;
            ready = 1'b1;
        end
        @(posedge clk); #1;
        ready = 1'b0;
        chk({name, "_valid_cleared"}, {31'b0, o_valid}, 32'd0);
        chk({name, "_sat_cleared"}, {31'b0, o_sat}, 32'd0);
        chk({name, "_idle_ready"}, {31'b0, o_ready}, 32'd0);
    endtask

    task automatic run_one(input string name, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] exp_d, input logic exp_s);
        int n;
        int last;
        q1.push_back({exp_s, exp_d});
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        valid = 1'b1;
        a = va;
        b = vb;
        @(posedge clk); #1;
        last = cyc;
        valid = 1'b0;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        n = 0;
        while (!o_valid1 && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 32'(cyc - last), 32'd2);
        @(posedge clk); #1;
        chk({name, "_valid_cleared"}, {31'b0, o_valid1}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        valid = 1'b0;
        ready = 1'b0;
        ready1 = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 32'h0);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_ready", {31'b0, o_ready}, 32'd0);
        chk("rst_sat", {31'b0, o_sat}, 32'd0);
        chk("rst_valid1", {31'b0, o_valid1}, 32'd0);
        rst = 1'b0;

        // Pulses while IDLE must not be counted into the next vector.
        valid = 1'b1;
        a = 32'h0001_0000;
        b = 32'h0001_0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("idle_ready", {31'b0, o_ready}, 32'd0);
        end
        valid = 1'b0;

        run_vec("basic",   32'h0001_0000, 32'h0002_0000, 7'b0, 0, 0, 32'h0008_0000, 1'b0);
        run_vec("mixed",   32'hFFFF_8000, 32'h0003_0000, 7'b0, 0, 3, 32'hFFFA_0000, 1'b0);
        run_vec("floor",   32'h0000_0001, 32'hFFFF_FFFF, 7'b0, 0, 1, 32'hFFFF_FFFC, 1'b0);
        run_vec("sat_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 7'b0, 0, 2, 32'h7FFF_FFFF, 1'b1);
        run_vec("sat_neg", 32'h8000_0000, 32'h7FFF_FFFF, 7'b0, 0, 0, 32'h8000_0000, 1'b1);
        run_vec("bubbles", 32'h0001_0000, 32'h0002_0000, 7'b1100101, 7, 5, 32'h0008_0000, 1'b0);

        // Abort a vector after two accepts; nothing from it may survive.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        valid = 1'b1;
        a = 32'h7FFF_FFFF;
        b = 32'h7FFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_dout", dout, 32'h0);
        chk("midrst_valid", {31'b0, o_valid}, 32'd0);
        chk("midrst_ready", {31'b0, o_ready}, 32'd0);
        chk("midrst_sat", {31'b0, o_sat}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec("after_rst", 32'h0001_0000, 32'h0001_0000, 7'b0, 0, 0, 32'h0004_0000, 1'b0);

        run_one("one_floor", 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
        run_one("one_mul",   32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard4_drained", 32'(q4.size()), 32'd0);
        chk("scoreboard1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
